// File: rtl/pe_ctx_sequencer.sv
// Configuration-context sequencer: loads a burst of PE instruction words, then replays them for N loops (or forever).
// Latency: entry 0 appears on inst_out one cycle after the run-acceptance edge; done is registered one cycle after the last issue.
// Backpressure: stall freezes issue while running (no valid, pointers hold); abort returns to IDLE from any state.
module pe_ctx_sequencer #(
    parameter int INST_W = 48,
    parameter int DEPTH  = 16,
    parameter int ITER_W = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] PE_inst,
    input  logic              init,
    input  logic              run,
    input  logic [ITER_W-1:0] iters,
    input  logic              stall,
    input  logic              abort,
    output logic [INST_W-1:0] inst_out,
    output logic              inst_valid,
    output logic [AW-1:0]     ctx_idx,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              busy,
    output logic              done,
    output logic              load_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]     ctx_len_q, ctx_len_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
    logic [ITER_W-1:0] iters_q, iters_d;
    logic [INST_W-1:0] inst_out_q, inst_out_d;
    logic [AW-1:0]     ctx_idx_q, ctx_idx_d;
    logic              inst_valid_q, inst_valid_d;
    logic              done_q, done_d;
    logic              load_err_q, load_err_d;

    // Context storage has no reset; only entries below ctx_len are ever read.
    logic [INST_W-1:0] ctx_mem [DEPTH];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;

    logic ctx_nonempty;
    logic load_room;
    logic last_entry;
    logic last_issue;

    assign ctx_nonempty = (ctx_len_q != '0);
    assign load_room    = (wr_ptr_q < LW'(DEPTH));
    assign last_entry   = (LW'(rd_ptr_q) == (ctx_len_q - LW'(1)));
    // Final issue of a bounded run: last entry of iteration iters-1.
    assign last_issue   = last_entry && (iters_q != '0) &&
                          (iter_cnt_q == (iters_q - ITER_W'(1)));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; abort overrides every other request.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (init) begin
                        state_d = S_LOAD;
                    end else if (run && ctx_nonempty) begin
                        state_d = S_RUN;
                    end
                end
                S_LOAD: begin
                    if (!init) begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (!stall && last_issue) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output and datapath next values for the current state.
    always_comb begin
        busy         = (state_q == S_RUN);
        wr_ptr_d     = wr_ptr_q;
        ctx_len_d    = ctx_len_q;
        rd_ptr_d     = rd_ptr_q;
        iter_cnt_d   = iter_cnt_q;
        iters_d      = iters_q;
        inst_out_d   = inst_out_q;
        ctx_idx_d    = ctx_idx_q;
        inst_valid_d = 1'b0;
        done_d       = 1'b0;
        load_err_d   = load_err_q;
        mem_we       = 1'b0;
        mem_waddr    = '0;
        if (abort) begin
            // An interrupted load still commits whatever was written.
            if (state_q == S_LOAD) begin
                ctx_len_d = wr_ptr_q;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (init) begin
                        mem_we     = 1'b1;
                        mem_waddr  = '0;
                        wr_ptr_d   = LW'(1);
                        load_err_d = 1'b0;
                    end else if (run && ctx_nonempty) begin
                        iters_d    = iters;
                        rd_ptr_d   = '0;
                        iter_cnt_d = '0;
                    end
                end
                S_LOAD: begin
                    if (init) begin
                        if (load_room) begin
                            mem_we    = 1'b1;
                            mem_waddr = wr_ptr_q[AW-1:0];
                            wr_ptr_d  = wr_ptr_q + LW'(1);
                        end else begin
                            load_err_d = 1'b1;
                        end
                    end else begin
                        ctx_len_d = wr_ptr_q;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        inst_out_d   = ctx_mem[rd_ptr_q];
                        ctx_idx_d    = rd_ptr_q;
                        inst_valid_d = 1'b1;
                        if (last_entry) begin
                            rd_ptr_d   = '0;
                            iter_cnt_d = iter_cnt_q + ITER_W'(1);
                        end else begin
                            rd_ptr_d = rd_ptr_q + AW'(1);
                        end
                    end
                end
                S_DONE: begin
                    done_d = 1'b1;
                end
            endcase
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            ctx_len_q    <= '0;
            rd_ptr_q     <= '0;
            iter_cnt_q   <= '0;
            iters_q      <= '0;
            inst_out_q   <= '0;
            ctx_idx_q    <= '0;
            inst_valid_q <= 1'b0;
            done_q       <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            ctx_len_q    <= ctx_len_d;
            rd_ptr_q     <= rd_ptr_d;
            iter_cnt_q   <= iter_cnt_d;
            iters_q      <= iters_d;
            inst_out_q   <= inst_out_d;
            ctx_idx_q    <= ctx_idx_d;
            inst_valid_q <= inst_valid_d;
            done_q       <= done_d;
            load_err_q   <= load_err_d;
        end
    end

    // Context buffer write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            ctx_mem[mem_waddr] <= PE_inst;
        end
    end

    assign inst_out   = inst_out_q;
    assign inst_valid = inst_valid_q;
    assign ctx_idx    = ctx_idx_q;
    assign iter_cnt   = iter_cnt_q;
    assign done       = done_q;
    assign load_err   = load_err_q;

endmodule
